// File: rtl/fetch_stage_pkg.sv
// Shared CPU defines: fetch reset/NOP constants, fetch FSM encoding, decode-side select codes.
package fetch_stage_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_KILL  = 2'd3
  } fetch_state_t;

  typedef enum logic {
    ALUB_RS2 = 1'b0,
    ALUB_IMM = 1'b1
  } alub_sel_t;

  typedef enum logic [1:0] {
    DRAM_BYTE = 2'd0,
    DRAM_HALF = 2'd1,
    DRAM_WORD = 2'd2
  } dram_size_t;

  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats stall beats load; no load gives a NOP bubble.
// One-cycle register; stall freezes every field.
module if_id_reg #(
  parameter logic [31:0] NOP_INST = fetch_stage_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        stall,
  input  logic        load,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_inst,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic [31:0] inst
);
  import fetch_stage_pkg::*;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      pc    <= 32'h0;
      pc4   <= 32'h0;
      inst  <= NOP_INST;
    end else if (flush) begin
      // pc/pc4 keep their last values so a squashed slot still reports where it was
      valid <= 1'b0;
      inst  <= NOP_INST;
    end else if (!stall) begin
      if (load) begin
        valid <= 1'b1;
        pc    <= load_pc;
        pc4   <= next_pc(load_pc);
        inst  <= load_inst;
      end else begin
        valid <= 1'b0;
        inst  <= NOP_INST;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding imem request, 1-entry hold buffer for load-use stalls, jump redirect.
// IF/ID loads on the ack edge (1 instr/cycle with 1-cycle acks); pipeline_stop parks the word, is_jump always wins.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = fetch_stage_pkg::RESET_PC,
  parameter logic [31:0] NOP_INST = fetch_stage_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pipeline_stop,
  input  logic        if_id_flush,
  input  logic        is_jump,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic [31:0] id_inst,
  output logic [31:0] stall_cnt
);
  import fetch_stage_pkg::*;

  fetch_state_t state, state_next;
  logic [31:0]  pc, pc_next;
  logic [31:0]  redirect, redirect_next;
  logic [31:0]  hold_inst, hold_inst_next;
  logic [31:0]  hold_pc, hold_pc_next;
  logic         load;
  logic [31:0]  load_pc, load_inst;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_RST;
      pc        <= RESET_PC;
      redirect  <= 32'h0;
      hold_inst <= 32'h0;
      hold_pc   <= 32'h0;
      stall_cnt <= 32'h0;
    end else begin
      state     <= state_next;
      pc        <= pc_next;
      redirect  <= redirect_next;
      hold_inst <= hold_inst_next;
      hold_pc   <= hold_pc_next;
      if (pipeline_stop && stall_cnt != 32'hFFFF_FFFF)
        stall_cnt <= stall_cnt + 32'd1;
    end
  end

  always_comb begin
    state_next     = state;
    pc_next        = pc;
    redirect_next  = redirect;
    hold_inst_next = hold_inst;
    hold_pc_next   = hold_pc;
    load           = 1'b0;
    load_pc        = pc;
    load_inst      = imem_rdata;
    imem_req       = 1'b0;
    case (state)
      ST_RST: begin
        state_next = ST_FETCH;
        if (is_jump)
          pc_next = jump_target;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          if (is_jump) begin
            pc_next = jump_target;
          end else if (pipeline_stop) begin
            hold_inst_next = imem_rdata;
            hold_pc_next   = pc;
            state_next     = ST_HOLD;
          end else begin
            load    = 1'b1;
            pc_next = next_pc(pc);
          end
        end else if (is_jump) begin
          // the request already on the bus must complete before we can redirect
          redirect_next = jump_target;
          state_next    = ST_KILL;
        end
      end
      ST_KILL: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          pc_next    = is_jump ? jump_target : redirect;
          state_next = ST_FETCH;
        end else if (is_jump) begin
          redirect_next = jump_target;
        end
      end
      ST_HOLD: begin
        if (is_jump) begin
          pc_next    = jump_target;
          state_next = ST_FETCH;
        end else if (!pipeline_stop) begin
          load       = 1'b1;
          load_pc    = hold_pc;
          load_inst  = hold_inst;
          pc_next    = next_pc(hold_pc);
          state_next = ST_FETCH;
        end
      end
      default: state_next = ST_RST;
    endcase
  end

  assign imem_addr = pc;

  if_id_reg #(
    .NOP_INST(NOP_INST)
  ) u_if_id (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (if_id_flush | is_jump),
    .stall    (pipeline_stop),
    .load     (load),
    .load_pc  (load_pc),
    .load_inst(load_inst),
    .valid    (id_valid),
    .pc       (id_pc),
    .pc4      (id_pc4),
    .inst     (id_inst)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Fetch stage bench: directed scenarios then random stop/jump/reset traffic against a latency-randomised memory.
module tb_fetch_stage;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pipeline_stop;
  logic        if_id_flush;
  logic        is_jump;
  logic [31:0] jump_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_pc, id_pc4, id_inst, stall_cnt;

  int          chk_cnt = 0;
  int          pass_cnt = 0;
  int          loads = 0;
  int          fixed_lat = 0;
  int          wait_left = -1;
  logic [31:0] key = 32'h0;
  logic [31:0] redir_q[$];
  logic [31:0] jt;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pipeline_stop(pipeline_stop),
    .if_id_flush  (if_id_flush),
    .is_jump      (is_jump),
    .jump_target  (jump_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .id_valid     (id_valid),
    .id_pc        (id_pc),
    .id_pc4       (id_pc4),
    .id_inst      (id_inst),
    .stall_cnt    (stall_cnt)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_jump(input logic [31:0] t);
    is_jump     = 1'b1;
    jump_target = t;
    redir_q.push_back(t);
  endtask

  // memory: word at address a is a ^ key; latency 1..3 cycles (fixed_lat extra waits when >= 0)
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      imem_ack = 1'b0;
      if (imem_req) begin
        if (wait_left < 0)
          wait_left = (fixed_lat >= 0) ? fixed_lat : $urandom_range(0, 2);
        if (wait_left == 0) begin
          imem_ack   = 1'b1;
          imem_rdata = imem_addr ^ key;
          wait_left  = -1;
        end else begin
          wait_left--;
        end
      end
    end
  end

  // monitor: architectural model = sequential program counter, redirected by each issued jump
  initial begin
    logic        started, p_rst, p_stop, p_jump, p_req, p_ack, poisoned;
    logic [31:0] p_addr, exp_pc, exp_stall, m_pc, m_pc4, m_inst;
    logic        m_valid;
    started = 1'b0; poisoned = 1'b0;
    p_rst = 1'b0; p_stop = 1'b0; p_jump = 1'b0; p_req = 1'b0; p_ack = 1'b0; p_addr = 32'h0;
    exp_pc = RST_PC; exp_stall = 32'h0;
    m_valid = 1'b0; m_pc = 32'h0; m_pc4 = 32'h0; m_inst = NOP;
    forever begin
      @(negedge clk);
      if (started) begin
        if (!p_rst) begin
          chk("rst_req", 32'(imem_req), 32'd0);
          chk("rst_valid", 32'(id_valid), 32'd0);
          chk("rst_inst", id_inst, NOP);
          chk("rst_pc", id_pc, 32'h0);
          chk("rst_pc4", id_pc4, 32'h0);
          chk("rst_stall", stall_cnt, 32'h0);
          exp_pc = RST_PC; exp_stall = 32'h0; poisoned = 1'b0;
          m_valid = 1'b0; m_pc = 32'h0; m_pc4 = 32'h0; m_inst = NOP;
          redir_q.delete();
        end else begin
          if (p_stop && exp_stall != 32'hFFFF_FFFF) exp_stall = exp_stall + 32'd1;
          chk("stall_cnt", stall_cnt, exp_stall);
          if (p_req && !p_ack) begin
            chk("req_held", 32'(imem_req), 32'd1);
            chk("addr_stable", imem_addr, p_addr);
          end
          if (p_req && p_ack && !p_stop && !p_jump && !poisoned)
            chk("ack_loads", 32'(id_valid), 32'd1);
          if (p_jump) begin
            if (redir_q.size() > 0) exp_pc = redir_q.pop_front();
            else chk("redir_q_nonempty", 32'd0, 32'd1);
            chk("jump_valid", 32'(id_valid), 32'd0);
            chk("jump_inst", id_inst, NOP);
            chk("jump_pc", id_pc, m_pc);
            chk("jump_pc4", id_pc4, m_pc4);
            m_valid = 1'b0; m_inst = NOP;
          end else if (p_stop) begin
            chk("stop_valid", 32'(id_valid), 32'(m_valid));
            chk("stop_pc", id_pc, m_pc);
            chk("stop_pc4", id_pc4, m_pc4);
            chk("stop_inst", id_inst, m_inst);
          end else if (id_valid) begin
            chk("load_pc", id_pc, exp_pc);
            chk("load_pc4", id_pc4, exp_pc + 32'd4);
            chk("load_inst", id_inst, exp_pc ^ key);
            m_valid = 1'b1; m_pc = exp_pc; m_pc4 = exp_pc + 32'd4; m_inst = exp_pc ^ key;
            exp_pc = exp_pc + 32'd4;
            loads++;
          end else begin
            chk("bubble_inst", id_inst, NOP);
            chk("bubble_pc", id_pc, m_pc);
            chk("bubble_pc4", id_pc4, m_pc4);
            m_valid = 1'b0; m_inst = NOP;
          end
          if (p_req && p_ack) poisoned = 1'b0;
          else if (p_req && p_jump) poisoned = 1'b1;
        end
      end
      started = 1'b1;
      p_rst = rst_n; p_stop = pipeline_stop; p_jump = is_jump;
      p_req = imem_req; p_ack = imem_ack; p_addr = imem_addr;
    end
  end

  initial begin
    rst_n = 1'b0; pipeline_stop = 1'b0; if_id_flush = 1'b0; is_jump = 1'b0; jump_target = 32'h0;
    fixed_lat = 0;
    repeat (3) tick();
    chk("A_rst_req", 32'(imem_req), 32'd0);
    chk("A_rst_valid", 32'(id_valid), 32'd0);
    chk("A_rst_stall", stall_cnt, 32'h0);

    // back-to-back single-cycle acks, rdata = addr
    rst_n = 1'b1;
    tick();
    chk("A_first_addr", imem_addr, RST_PC);
    chk("A_not_valid_yet", 32'(id_valid), 32'd0);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("A_seq_valid", 32'(id_valid), 32'd1);
      chk("A_seq_pc", id_pc, 32'(k * 4));
    end

    // stop for 3 cycles while the word at 0x8 is acked
    chk("B_addr8", imem_addr, 32'h8);
    pipeline_stop = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("B_hold_pc", id_pc, 32'h4);
      chk("B_hold_valid", 32'(id_valid), 32'd1);
      chk("B_no_req", 32'(imem_req), 32'd0);
    end
    pipeline_stop = 1'b0;
    tick();
    chk("B_release_pc", id_pc, 32'h8);
    chk("B_stall_cnt", stall_cnt, 32'd3);
    tick();
    chk("B_next_pc", id_pc, 32'hC);

    // jump while the request to 0x10 is still outstanding
    fixed_lat = 2;
    do_jump(32'h100);
    tick();
    is_jump = 1'b0;
    chk("C_kill_valid", 32'(id_valid), 32'd0);
    chk("C_kill_inst", id_inst, NOP);
    chk("C_kill_addr", imem_addr, 32'h10);
    tick();
    chk("C_kill_addr2", imem_addr, 32'h10);
    tick();
    chk("C_redirect_addr", imem_addr, 32'h100);
    chk("C_no_stale", 32'(id_valid), 32'd0);
    fixed_lat = 0;
    tick();
    chk("C_target_pc", id_pc, 32'h100);

    // jump and stop together
    do_jump(32'h200);
    pipeline_stop = 1'b1;
    tick();
    is_jump = 1'b0; pipeline_stop = 1'b0;
    chk("D_valid", 32'(id_valid), 32'd0);
    chk("D_inst", id_inst, 32'h0000_0013);
    chk("D_addr", imem_addr, 32'h200);

    // pc wrap
    do_jump(32'hFFFF_FFF8);
    tick();
    is_jump = 1'b0;
    chk("E_addr", imem_addr, 32'hFFFF_FFF8);
    tick();
    chk("E_pc_fff8", id_pc, 32'hFFFF_FFF8);
    tick();
    chk("E_pc_fffc", id_pc, 32'hFFFF_FFFC);
    chk("E_pc4_wrap", id_pc4, 32'h0);
    chk("E_addr_wrap", imem_addr, 32'h0);

    // reset while killing, with an ack in the reset cycle
    fixed_lat = 1;
    do_jump(32'h40);
    tick();
    is_jump = 1'b0;
    chk("F_kill_req", 32'(imem_req), 32'd1);
    chk("F_kill_addr", imem_addr, 32'h0);
    rst_n = 1'b0;
    key = 32'hC0DE_0000;
    tick();
    chk("F_rst_req", 32'(imem_req), 32'd0);
    chk("F_rst_valid", 32'(id_valid), 32'd0);
    chk("F_rst_inst", id_inst, NOP);
    chk("F_rst_pc", id_pc, 32'h0);
    chk("F_rst_pc4", id_pc4, 32'h0);
    chk("F_rst_stall", stall_cnt, 32'h0);
    rst_n = 1'b1;
    fixed_lat = -1;
    tick();
    chk("F_post_rst_req", 32'(imem_req), 32'd1);
    chk("F_post_rst_addr", imem_addr, RST_PC);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 399) != 0);
      pipeline_stop = ($urandom_range(0, 3) == 0);
      is_jump = 1'b0;
      if_id_flush = 1'b0;
      if (rst_n && $urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 7) == 0) jt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 32'd4;
        else jt = $urandom & 32'h0000_FFFC;
        do_jump(jt);
        if_id_flush = ($urandom_range(0, 1) == 1);
      end
      tick();
    end
    rst_n = 1'b1; pipeline_stop = 1'b0; is_jump = 1'b0; if_id_flush = 1'b0;
    repeat (4) tick();
    chk("liveness_loads_ge_200", 32'(loads >= 200), 32'd1);
    #10;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
